// File: rtl/song_frame_sequencer.sv
// ---------------------------------------------------------------------------
// SongFrameSequencer (top: song_frame_sequencer)
//
// Plays a song image stored in ROM frame by frame for the MusicBox PlaySong
// states. Each frame holds CHANNELS (frequency, amplitude) word pairs, which
// are fetched into shadow registers and then committed to the channel buses
// in a single cycle. A new frame is committed every FRAME_MS ticks of the
// 1 kHz strobe.
//
// Ports:
//   clock_50Mhz        system clock
//   reset_n            asynchronous active-low reset
//   tick_1khz          one-cycle 1 kHz strobe
//   start              begin playback from frame 0 (from IDLE or DONE)
//   abort              stop playback (PRIME or RUN)
//   loop_en            wrap to frame 0 after the last frame
//   rom_index          ROM read address
//   rom_data           ROM read data, valid ROM_LATENCY cycles after address
//   channel_frequency  channel k at [k*FREQ_W +: FREQ_W]
//   channel_amplitude  channel k at [k*AMP_W +: AMP_W]
//   output_active      a frame is being played
//   state_complete     song finished or aborted (level)
//   current_frame      index of the frame on the channel buses
//   busy               priming or running
//
// Optional feature macro: SONG_FRAME_SEQUENCER_END_MARKER_EN
//   When defined, a channel-0 frequency word of 16'hFFFF ends the song.
// ---------------------------------------------------------------------------
module song_frame_sequencer #(
  parameter int CHANNELS    = 3,
  parameter int FREQ_W      = 14,
  parameter int AMP_W       = 8,
  parameter int ROM_ADDR_W  = 16,
  parameter int ROM_LATENCY = 1,
  parameter int FRAME_MS    = 10,
  parameter int FRAME_COUNT = 184,
  parameter int BASE_ADDR   = 0
) (
  input  logic                       clock_50Mhz,
  input  logic                       reset_n,
  input  logic                       tick_1khz,
  input  logic                       start,
  input  logic                       abort,
  input  logic                       loop_en,
  output logic [ROM_ADDR_W-1:0]      rom_index,
  input  logic [15:0]                rom_data,
  output logic [CHANNELS*FREQ_W-1:0] channel_frequency,
  output logic [CHANNELS*AMP_W-1:0]  channel_amplitude,
  output logic                       output_active,
  output logic                       state_complete,
  output logic [15:0]                current_frame,
  output logic                       busy
);

  localparam int NWORDS   = 2 * CHANNELS;
  localparam int LAST_CNT = NWORDS + ROM_LATENCY - 1;
  localparam int MS_W     = (FRAME_MS > 1) ? $clog2(FRAME_MS) : 1;
  localparam logic [15:0] LAST_FRAME = 16'(FRAME_COUNT - 1);

  typedef enum logic [1:0] {IDLE, PRIME, RUN, DONE} state_t;

  state_t                     r_state;
  state_t                     w_nextState;
  logic                       r_fetchBusy;
  logic                       r_fetchDone;
  logic [5:0]                 r_fetchCnt;
  logic [15:0]                r_framePtr;
  logic [CHANNELS*FREQ_W-1:0] r_shadowFreq;
  logic [CHANNELS*AMP_W-1:0]  r_shadowAmp;
  logic [MS_W-1:0]            r_msCnt;

  logic                       w_marker;
  logic                       w_expire;
  logic                       w_launch;
  logic                       w_commit;
  logic                       w_toDone;
  logic                       w_restart;
  logic                       w_msInc;
  logic [15:0]                w_launchFrame;
  logic [15:0]                w_nextFrame;
  logic [5:0]                 w_capIdx;
  logic [ROM_ADDR_W-1:0]      w_launchAddr;
  logic                       w_unusedRomBits;

  // Upper data bits beyond the field widths are intentionally ignored.
  assign w_unusedRomBits = ^rom_data;

  assign busy         = (r_state == PRIME) || (r_state == RUN);
  assign w_expire     = tick_1khz && (r_msCnt == MS_W'(FRAME_MS - 1));
  // Frame after the one held in the shadow; wraps so a looping song can
  // prefetch frame 0 before loop_en is sampled at expiry.
  assign w_nextFrame  = (r_framePtr == LAST_FRAME) ? 16'd0 : r_framePtr + 16'd1;
  assign w_capIdx     = r_fetchCnt - 6'(ROM_LATENCY);
  assign w_launchAddr = ROM_ADDR_W'(BASE_ADDR)
                      + ROM_ADDR_W'(w_launchFrame) * ROM_ADDR_W'(NWORDS);

`ifdef SONG_FRAME_SEQUENCER_END_MARKER_EN
  logic r_marker;

  // Channel-0 frequency word is the first word captured by each fetch.
  always_ff @(posedge clock_50Mhz or negedge reset_n) begin
    if (!reset_n) begin
      r_marker <= 1'b0;
    end else if (w_launch) begin
      r_marker <= 1'b0;
    end else if (r_fetchBusy && (r_fetchCnt == 6'(ROM_LATENCY))) begin
      r_marker <= (rom_data == 16'hFFFF);
    end
  end

  assign w_marker = r_marker;
`else
  assign w_marker = 1'b0;
`endif

  // Next-state and control strobes. abort is checked first in PRIME/RUN so
  // it wins over expiry and start.
  always_comb begin
    w_nextState   = r_state;
    w_launch      = 1'b0;
    w_launchFrame = 16'd0;
    w_commit      = 1'b0;
    w_toDone      = 1'b0;
    w_restart     = 1'b0;
    w_msInc       = 1'b0;
    case (r_state)
      IDLE, DONE: begin
        if (start) begin
          w_nextState = PRIME;
          w_launch    = 1'b1;
          w_restart   = 1'b1;
        end
      end
      PRIME: begin
        if (abort) begin
          w_nextState = DONE;
          w_toDone    = 1'b1;
        end else if (r_fetchDone) begin
          if (w_marker) begin
            w_nextState = DONE;
            w_toDone    = 1'b1;
          end else begin
            w_nextState   = RUN;
            w_commit      = 1'b1;
            w_launch      = 1'b1;
            w_launchFrame = w_nextFrame;
          end
        end
      end
      RUN: begin
        if (abort) begin
          w_nextState = DONE;
          w_toDone    = 1'b1;
        end else if (w_expire) begin
          if (((current_frame == LAST_FRAME) && !loop_en) || (r_fetchDone && w_marker)) begin
            w_nextState = DONE;
            w_toDone    = 1'b1;
          end else if (r_fetchDone) begin
            w_commit      = 1'b1;
            w_launch      = 1'b1;
            w_launchFrame = w_nextFrame;
          end
        end else if (tick_1khz) begin
          w_msInc = 1'b1;
        end
      end
      default: w_nextState = IDLE;
    endcase
  end

  // State register, fetch engine and committed outputs. The fetch engine
  // walks rom_index through the frame and captures word (cnt - ROM_LATENCY)
  // on each cycle once the ROM pipeline has filled.
  always_ff @(posedge clock_50Mhz or negedge reset_n) begin
    if (!reset_n) begin
      r_state           <= IDLE;
      r_fetchBusy       <= 1'b0;
      r_fetchDone       <= 1'b0;
      r_fetchCnt        <= '0;
      r_framePtr        <= '0;
      r_shadowFreq      <= '0;
      r_shadowAmp       <= '0;
      r_msCnt           <= '0;
      rom_index         <= '0;
      channel_frequency <= '0;
      channel_amplitude <= '0;
      output_active     <= 1'b0;
      state_complete    <= 1'b0;
      current_frame     <= '0;
    end else begin
      r_state <= w_nextState;

      if (w_launch) begin
        r_fetchBusy <= 1'b1;
        r_fetchDone <= 1'b0;
        r_fetchCnt  <= '0;
        r_framePtr  <= w_launchFrame;
        rom_index   <= w_launchAddr;
      end else if (w_toDone) begin
        r_fetchBusy <= 1'b0;
        r_fetchDone <= 1'b0;
      end else if (r_fetchBusy) begin
        if (r_fetchCnt == 6'(LAST_CNT)) begin
          r_fetchBusy <= 1'b0;
          r_fetchDone <= 1'b1;
        end else begin
          r_fetchCnt <= r_fetchCnt + 6'd1;
        end
        if (r_fetchCnt < 6'(NWORDS - 1)) begin
          rom_index <= rom_index + ROM_ADDR_W'(1);
        end
        if (r_fetchCnt >= 6'(ROM_LATENCY)) begin
          for (int k = 0; k < CHANNELS; k++) begin
            if (w_capIdx == 6'(2 * k)) begin
              r_shadowFreq[k*FREQ_W +: FREQ_W] <= rom_data[FREQ_W-1:0];
            end
            if (w_capIdx == 6'(2 * k + 1)) begin
              r_shadowAmp[k*AMP_W +: AMP_W] <= rom_data[AMP_W-1:0];
            end
          end
        end
      end

      if (w_commit) begin
        channel_frequency <= r_shadowFreq;
        channel_amplitude <= r_shadowAmp;
        current_frame     <= r_framePtr;
        output_active     <= 1'b1;
      end
      if (w_toDone) begin
        channel_amplitude <= '0;
        output_active     <= 1'b0;
        state_complete    <= 1'b1;
      end
      if (w_restart) begin
        state_complete <= 1'b0;
        current_frame  <= '0;
      end

      if (w_commit) begin
        r_msCnt <= '0;
      end else if (w_msInc) begin
        r_msCnt <= r_msCnt + MS_W'(1);
      end
    end
  end

endmodule
